ram: RTL and testbench

RAM -- requirements
Module: ram

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_port.sv | 51 +++++
 rtl/ram.sv | 81 ++++++++
 tb/tb_ram.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and word/address types for the dual-port RAM slice.
package ram_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 2 ** ADDR_W_DEFAULT;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
    typedef logic [DATA_W_DEFAULT-1:0] word_t;

endpackage

// File: rtl/ram_port.sv
// One RAM port: turns the port address/write-enable into a one-hot
// word-select for the shared array and owns the registered read data.
module ram_port
    import ram_pkg::*;
#(
    parameter int ADDR_W = ram_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = ram_pkg::DATA_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      data,
    input  logic                   wren,
    input  logic [DATA_W-1:0]      rd_word,
    output logic [(2**ADDR_W)-1:0] wr_sel,
    output logic [DATA_W-1:0]      q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  wr_sel_s;
    logic [DATA_W-1:0] q_r;

    // Decode the write address into a one-hot select, empty when not writing.
    always_comb begin
        wr_sel_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (wren && (address == ADDR_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Read register: a write on this port is passed straight through so the
    // port sees its own new data; otherwise the pre-edge array word is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= {DATA_W{1'b0}};
        end else if (wren) begin
            q_r <= data;
        end else begin
            q_r <= rd_word;
        end
    end

    assign wr_sel = wr_sel_s;
    assign q      = q_r;

endmodule

// File: rtl/ram.sv
// True dual-port RAM built from flops so the whole array can be cleared
// asynchronously. Port B wins a same-address write collision; a port reading
// a word the other port is writing sees the old contents.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = ram_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = ram_pkg::DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  wr_sel_a_s;
    logic [DEPTH-1:0]  wr_sel_b_s;
    logic [DATA_W-1:0] rd_word_a_s;
    logic [DATA_W-1:0] rd_word_b_s;

    assign rd_word_a_s = mem_r[address_a];
    assign rd_word_b_s = mem_r[address_b];

    ram_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_a (
        .clock   (clock),
        .reset   (reset),
        .address (address_a),
        .data    (data_a),
        .wren    (wren_a),
        .rd_word (rd_word_a_s),
        .wr_sel  (wr_sel_a_s),
        .q       (q_a)
    );

    ram_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_b (
        .clock   (clock),
        .reset   (reset),
        .address (address_b),
        .data    (data_b),
        .wren    (wren_b),
        .rd_word (rd_word_b_s),
        .wr_sel  (wr_sel_b_s),
        .q       (q_b)
    );

    // Storage array: async clear of every word, port B checked first so it
    // wins when both ports target the same word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel_b_s[i]) begin
                    mem_r[i] <= data_b;
                end else if (wr_sel_a_s[i]) begin
                    mem_r[i] <= data_a;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram.sv
// Directed bench for the dual-port RAM with hand-computed expected values.
module tb_ram;
    import ram_pkg::*;

    logic  clock;
    logic  reset;
    addr_t address_a;
    word_t data_a;
    logic  wren_a;
    word_t q_a;
    addr_t address_b;
    word_t data_b;
    logic  wren_b;
    word_t q_b;

    int checks;
    int errors;

    ram dut (
        .clock     (clock),
        .reset     (reset),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .q_a       (q_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .q_b       (q_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        address_a = 5'd0;
        address_b = 5'd0;
        data_a    = 32'd0;
        data_b    = 32'd0;
        wren_a    = 1'b0;
        wren_b    = 1'b0;

        tick();
        tick();
        check("reset_q_a", q_a, 32'd0);
        check("reset_q_b", q_b, 32'd0);
        reset = 1'b0;

        // Every word reads zero after reset, on both ports.
        for (int i = 0; i < 32; i++) begin
            address_a = addr_t'(i);
            address_b = addr_t'(31 - i);
            tick();
            check("clear_a", q_a, 32'd0);
            check("clear_b", q_b, 32'd0);
        end

        // Fill 0..30 with i*i through port A; write-through shows new data.
        for (int i = 0; i < 31; i++) begin
            address_a = addr_t'(i);
            data_a    = word_t'(i * i);
            wren_a    = 1'b1;
            tick();
            check("wr_through_a", q_a, word_t'(i * i));
        end
        wren_a = 1'b0;

        for (int i = 0; i < 31; i++) begin
            address_a = addr_t'(i);
            tick();
            check("square_rd_a", q_a, word_t'(i * i));
        end
        address_a = 5'd10;
        tick();
        check("square_10", q_a, 32'd100);

        // q holds between edges even when the address moves.
        address_a = 5'd12;
        #3;
        check("q_hold", q_a, 32'd100);
        tick();
        check("square_12", q_a, 32'd144);

        // Mixed-port read-during-write: B sees old data, then new.
        address_a = 5'd5;
        data_a    = 32'hDEADBEEF;
        wren_a    = 1'b1;
        address_b = 5'd5;
        tick();
        check("mixed_old_b", q_b, 32'd25);
        check("mixed_wt_a", q_a, 32'hDEADBEEF);
        wren_a = 1'b0;
        tick();
        check("mixed_new_b", q_b, 32'hDEADBEEF);

        // Both ports write address 7: B stored, each port sees its own data.
        address_a = 5'd7;
        address_b = 5'd7;
        data_a    = 32'h0000_1111;
        data_b    = 32'h0000_2222;
        wren_a    = 1'b1;
        wren_b    = 1'b1;
        tick();
        check("collide_q_a", q_a, 32'h0000_1111);
        check("collide_q_b", q_b, 32'h0000_2222);
        wren_a = 1'b0;
        wren_b = 1'b0;
        tick();
        check("collide_rd_a", q_a, 32'h0000_2222);
        check("collide_rd_b", q_b, 32'h0000_2222);

        // Top address via port B, read back on A; neighbours untouched.
        address_b = 5'd31;
        data_b    = 32'hA5A5A5A5;
        wren_b    = 1'b1;
        address_a = 5'd0;
        tick();
        check("top_wt_b", q_b, 32'hA5A5A5A5);
        wren_b    = 1'b0;
        address_a = 5'd31;
        address_b = 5'd30;
        tick();
        check("top_rd_a", q_a, 32'hA5A5A5A5);
        check("below_top_b", q_b, 32'd900);
        address_a = 5'd0;
        tick();
        check("no_wrap_0", q_a, 32'd0);

        // Reset between edges clears outputs and array immediately.
        address_a = 5'd3;
        address_b = 5'd7;
        tick();
        check("pre_rst_a", q_a, 32'd9);
        check("pre_rst_b", q_b, 32'h0000_2222);
        data_a = 32'h0000_BEEF;
        wren_a = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst_now_a", q_a, 32'd0);
        check("rst_now_b", q_b, 32'd0);
        check("rst_now_mem3", dut.mem_r[3], 32'd0);

        // Writes across an edge while reset is high are ignored.
        tick();
        check("rst_hold_a", q_a, 32'd0);
        check("rst_hold_mem3", dut.mem_r[3], 32'd0);
        #2;
        reset  = 1'b0;
        wren_a = 1'b0;
        tick();
        check("post_rst_a", q_a, 32'd0);
        check("post_rst_b", q_b, 32'd0);

        // Normal operation resumes on the first edge after release.
        data_a = 32'h0000_0033;
        wren_a = 1'b1;
        tick();
        check("post_rst_wr_a", q_a, 32'h0000_0033);
        wren_a    = 1'b0;
        address_b = 5'd3;
        tick();
        check("post_rst_rd_b", q_b, 32'h0000_0033);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
